// File: rtl/awg_pkg.sv
// Shared types and helpers for the AWG burst sequencer.
package awg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } burst_state_t;

  // Clock cycles per millisecond, never below one so the prescaler stays legal.
  function automatic int unsigned MS_DIV_CYCLES(input int unsigned clk_hz);
    int unsigned div_v;
    div_v = clk_hz / 32'd1000;
    return (div_v == 32'd0) ? 32'd1 : div_v;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle registered tick every DIV cycles, held at zero while restart=1.
module ms_tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 32'd1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Prescaler counter and registered tick pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (restart) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_r <= cnt_r + ONE;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/burst_controller.sv
// Burst sequencer for the AWG phase accumulator (IDLE/ARM/RUN/GAP, ms-timed gaps).
// Optional macro BURST_RETRIGGER_EN: a trigger in RUN or GAP restarts the burst.
module burst_controller
  import awg_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             stop,
  input  logic             enable,
  input  logic             auto_repeat,
  input  logic [CNT_W-1:0] burst_cycles,
  input  logic [CNT_W-1:0] gap_ms,
  input  logic             phase_msb,
  output logic             nco_run,
  output logic             nco_clear,
  output logic             wave_gate,
  output logic             busy,
  output logic [CNT_W-1:0] cycles_done
);

  localparam int unsigned      MS_DIV  = MS_DIV_CYCLES(CLK_FREQ_HZ);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  burst_state_t     state_r, nxt_state_s;
  logic [CNT_W-1:0] burst_lat_r, burst_nxt_s;
  logic [CNT_W-1:0] gap_lat_r, gap_nxt_s;
  logic [CNT_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic [CNT_W-1:0] done_nxt_s, done_inc_s;
  logic             auto_lat_r, auto_nxt_s;
  logic             phase_d_r;
  logic             wrap_s, tick_s, tick_restart_s, retrig_s;

  assign wrap_s         = phase_d_r & ~phase_msb;
  assign tick_restart_s = (state_r != GAP);

`ifdef BURST_RETRIGGER_EN
  assign retrig_s = trigger;
`else
  assign retrig_s = 1'b0;
`endif

  ms_tick_gen #(.DIV(MS_DIV)) u_ms_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (tick_restart_s),
    .tick    (tick_s)
  );

  // Next-state and counter update; stop and enable=0 override everything else.
  always_comb begin
    nxt_state_s   = state_r;
    burst_nxt_s   = burst_lat_r;
    gap_nxt_s     = gap_lat_r;
    auto_nxt_s    = auto_lat_r;
    gap_cnt_nxt_s = '0;
    done_nxt_s    = cycles_done;
    done_inc_s    = (cycles_done == '1) ? cycles_done : cycles_done + CNT_ONE;
    if (stop || !enable) begin
      nxt_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (trigger) begin
            nxt_state_s = ARM;
          end else begin
            nxt_state_s = IDLE;
          end
        end
        ARM: begin
          nxt_state_s = RUN;
          burst_nxt_s = burst_cycles;
          gap_nxt_s   = gap_ms;
          auto_nxt_s  = auto_repeat;
          done_nxt_s  = '0;
        end
        RUN: begin
          if (retrig_s) begin
            nxt_state_s = ARM;
          end else if (wrap_s) begin
            done_nxt_s = done_inc_s;
            if ((burst_lat_r != '0) && (done_inc_s == burst_lat_r)) begin
              nxt_state_s = auto_lat_r ? GAP : IDLE;
            end else begin
              nxt_state_s = RUN;
            end
          end else begin
            nxt_state_s = RUN;
          end
        end
        GAP: begin
          gap_cnt_nxt_s = gap_cnt_r;
          if (retrig_s || (gap_lat_r == '0)) begin
            nxt_state_s = ARM;
          end else if (tick_s) begin
            if ((gap_cnt_r + CNT_ONE) == gap_lat_r) begin
              nxt_state_s = ARM;
            end else begin
              gap_cnt_nxt_s = gap_cnt_r + CNT_ONE;
            end
          end else begin
            nxt_state_s = GAP;
          end
        end
        default: begin
          nxt_state_s = IDLE;
        end
      endcase
    end
  end

  // State, latched burst parameters, and outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      burst_lat_r <= '0;
      gap_lat_r   <= '0;
      auto_lat_r  <= 1'b0;
      gap_cnt_r   <= '0;
      phase_d_r   <= 1'b0;
      cycles_done <= '0;
      nco_run     <= 1'b0;
      nco_clear   <= 1'b0;
      wave_gate   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= nxt_state_s;
      burst_lat_r <= burst_nxt_s;
      gap_lat_r   <= gap_nxt_s;
      auto_lat_r  <= auto_nxt_s;
      gap_cnt_r   <= gap_cnt_nxt_s;
      phase_d_r   <= phase_msb;
      cycles_done <= (nxt_state_s == ARM) ? '0 : done_nxt_s;
      busy        <= (nxt_state_s != IDLE);
      case (nxt_state_s)
        IDLE: begin
          // With burst mode off the accumulator free-runs and the waveform is shown.
          nco_run   <= ~enable;
          wave_gate <= ~enable;
          nco_clear <= 1'b0;
        end
        ARM: begin
          nco_run   <= 1'b0;
          wave_gate <= 1'b0;
          nco_clear <= 1'b1;
        end
        RUN: begin
          nco_run   <= 1'b1;
          wave_gate <= 1'b1;
          nco_clear <= 1'b0;
        end
        GAP: begin
          nco_run   <= 1'b0;
          wave_gate <= 1'b0;
          nco_clear <= 1'b0;
        end
        default: begin
          nco_run   <= 1'b0;
          wave_gate <= 1'b0;
          nco_clear <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_controller.sv
// Directed bench for burst_controller: single-cycle vector table plus multi-cycle sequences.
module tb_burst_controller;

  localparam int CNT_W = 10;
  localparam int NVEC  = 20;

  logic             clk = 1'b0;
  logic             rst_n, trigger, stop, enable, auto_repeat, phase_msb;
  logic [CNT_W-1:0] burst_cycles, gap_ms, cycles_done;
  logic             nco_run, nco_clear, wave_gate, busy;

  int checks = 0;
  int errors = 0;
  int tog_per = 8;
  int tog_cnt = 0;
  bit tog_en = 1'b0;

  typedef struct {
    logic             trig, stp, en, msb;
    logic             ex_busy, ex_run, ex_clr, ex_gate;
    logic [CNT_W-1:0] ex_done;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  burst_controller #(.CLK_FREQ_HZ(10000), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger      (trigger),
    .stop         (stop),
    .enable       (enable),
    .auto_repeat  (auto_repeat),
    .burst_cycles (burst_cycles),
    .gap_ms       (gap_ms),
    .phase_msb    (phase_msb),
    .nco_run      (nco_run),
    .nco_clear    (nco_clear),
    .wave_gate    (wave_gate),
    .busy         (busy),
    .cycles_done  (cycles_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; phase_msb toggles every tog_per cycles when the toggler is on.
  task automatic step();
    @(posedge clk);
    #1;
    if (tog_en) begin
      tog_cnt++;
      if (tog_cnt >= tog_per) begin
        tog_cnt   = 0;
        phase_msb = ~phase_msb;
      end
    end
  endtask

  task automatic setv(input int i, input logic t, input logic s, input logic e, input logic m,
                      input logic b, input logic r, input logic c, input logic g, input int d);
    vecs[i].trig = t; vecs[i].stp = s; vecs[i].en = e; vecs[i].msb = m;
    vecs[i].ex_busy = b; vecs[i].ex_run = r; vecs[i].ex_clr = c; vecs[i].ex_gate = g;
    vecs[i].ex_done = CNT_W'(d);
  endtask

  task automatic wait_done(input int target, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (cycles_done == CNT_W'(target)) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    bit to;
    int clr_cnt, gap_len, bad;

    //        trg stp en msb  busy run clr gate done   (burst_cycles=2, auto_repeat=0)
    setv( 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
    setv( 1, 1, 0, 1, 0,   1, 0, 1, 0, 0);
    setv( 2, 0, 0, 1, 0,   1, 1, 0, 1, 0);
    setv( 3, 0, 0, 1, 1,   1, 1, 0, 1, 0);
    setv( 4, 0, 0, 1, 0,   1, 1, 0, 1, 1);
    setv( 5, 0, 0, 1, 0,   1, 1, 0, 1, 1);
    setv( 6, 0, 0, 1, 1,   1, 1, 0, 1, 1);
    setv( 7, 0, 0, 1, 0,   0, 0, 0, 0, 2);
    setv( 8, 0, 0, 1, 0,   0, 0, 0, 0, 2);
    setv( 9, 1, 1, 1, 0,   0, 0, 0, 0, 2);
    setv(10, 1, 0, 1, 0,   1, 0, 1, 0, 0);
    setv(11, 0, 0, 1, 0,   1, 1, 0, 1, 0);
    setv(12, 0, 0, 1, 1,   1, 1, 0, 1, 0);
    setv(13, 0, 1, 1, 0,   0, 0, 0, 0, 0);
    setv(14, 0, 0, 0, 0,   0, 1, 0, 1, 0);
    setv(15, 1, 0, 0, 0,   0, 1, 0, 1, 0);
    setv(16, 1, 0, 1, 0,   1, 0, 1, 0, 0);
    setv(17, 0, 0, 1, 0,   1, 1, 0, 1, 0);
    setv(18, 0, 0, 0, 0,   0, 1, 0, 1, 0);
    setv(19, 0, 0, 1, 0,   0, 0, 0, 0, 0);

    rst_n = 1'b0; trigger = 1'b0; stop = 1'b0; enable = 1'b1; auto_repeat = 1'b0;
    phase_msb = 1'b0; burst_cycles = CNT_W'(2); gap_ms = CNT_W'(0);
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_run", nco_run, 0);
    chk("rst_clr", nco_clear, 0);
    chk("rst_gate", wave_gate, 0);
    chk("rst_done", cycles_done, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      trigger = vecs[i].trig; stop = vecs[i].stp; enable = vecs[i].en; phase_msb = vecs[i].msb;
      step();
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].ex_busy);
      chk($sformatf("vec%0d_run", i), nco_run, vecs[i].ex_run);
      chk($sformatf("vec%0d_clr", i), nco_clear, vecs[i].ex_clr);
      chk($sformatf("vec%0d_gate", i), wave_gate, vecs[i].ex_gate);
      chk($sformatf("vec%0d_done", i), cycles_done, vecs[i].ex_done);
    end
    trigger = 1'b0; stop = 1'b0; enable = 1'b1;

    // Single burst of three periods.
    burst_cycles = CNT_W'(3); auto_repeat = 1'b0; phase_msb = 1'b0;
    tog_per = 8; tog_cnt = 0; tog_en = 1'b1;
    step();
    trigger = 1'b1; step(); trigger = 1'b0;
    chk("a_clear", nco_clear, 1);
    clr_cnt = 1; to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (nco_clear) clr_cnt++;
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    chk("a_timeout", to, 0);
    chk("a_clear_cycles", clr_cnt, 1);
    chk("a_done", cycles_done, 3);
    chk("a_run", nco_run, 0);
    chk("a_gate", wave_gate, 0);

    // Auto-repeat with a 3 ms gap at 10 cycles per ms.
    burst_cycles = CNT_W'(2); gap_ms = CNT_W'(3); auto_repeat = 1'b1;
    trigger = 1'b1; step(); trigger = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy && !nco_run && !nco_clear) begin
        to = 1'b0;
        break;
      end
    end
    chk("b_gap_timeout", to, 0);
    chk("b_gap_done", cycles_done, 2);
    gap_len = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy && !nco_run && !nco_clear) gap_len++;
      else break;
    end
    chk("b_gap_len_in_29_31", (gap_len >= 29 && gap_len <= 31), 1);
    chk("b_rearm_clear", nco_clear, 1);
    chk("b_rearm_done", cycles_done, 0);
    step();
    chk("b_second_run", nco_run, 1);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!nco_run) begin
        to = 1'b0;
        break;
      end
    end
    chk("b_second_timeout", to, 0);
    chk("b_second_busy", busy, 1);
    chk("b_second_done", cycles_done, 2);
    stop = 1'b1; step(); stop = 1'b0;
    chk("b_stop_busy", busy, 0);

    // Asynchronous reset in the middle of an endless burst.
    burst_cycles = CNT_W'(0); auto_repeat = 1'b0;
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_done(5, 300, to);
    chk("c_reach5_timeout", to, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("c_rst_busy", busy, 0);
    chk("c_rst_run", nco_run, 0);
    chk("c_rst_gate", wave_gate, 0);
    chk("c_rst_clr", nco_clear, 0);
    chk("c_rst_done", cycles_done, 0);
    step(); step();
    rst_n = 1'b1;
    trigger = 1'b1; step(); trigger = 1'b0;
    chk("c_arm_clear", nco_clear, 1);
    chk("c_arm_done", cycles_done, 0);
    step();
    chk("c_run", nco_run, 1);
    stop = 1'b1; step(); stop = 1'b0;

    // Trigger while running at cycles_done=2.
    burst_cycles = CNT_W'(5);
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_done(2, 200, to);
    chk("d_reach2_timeout", to, 0);
    trigger = 1'b1; step(); trigger = 1'b0;
`ifdef BURST_RETRIGGER_EN
    chk("d_retrig_clear", nco_clear, 1);
    chk("d_retrig_done", cycles_done, 0);
`else
    chk("d_ignore_clear", nco_clear, 0);
    chk("d_ignore_done", cycles_done, 2);
`endif
    chk("d_busy", busy, 1);
    stop = 1'b1; step(); stop = 1'b0;

    // Endless burst: count saturates, only stop ends it.
    burst_cycles = CNT_W'(0); tog_per = 1; tog_cnt = 0;
    trigger = 1'b1; step(); trigger = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < 3100; i++) begin
      step();
      if (!busy || !nco_run) bad++;
    end
    chk("e_left_run_cycles", bad, 0);
    chk("e_saturated", cycles_done, 1023);
    stop = 1'b1; step(); stop = 1'b0;
    chk("e_stop_busy", busy, 0);
    chk("e_stop_run", nco_run, 0);
    chk("e_hold_done", cycles_done, 1023);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
